// File: rtl/clean_mode_timer_pkg.sv
// Shared constants for the hood clean-mode path: default timing, clean-state encodings
// and top-level mode codes.
package clean_mode_timer_pkg;

   localparam int DEF_CLK_FREQ      = 100_000_000;
   localparam int DEF_CLEAN_SECONDS = 180;
   localparam int DEF_CNT_WIDTH     = 27;

   localparam int CLEAN_STATE_WIDTH = 2;
   localparam logic [CLEAN_STATE_WIDTH-1:0] CLEAN_IDLE   = 2'd0;
   localparam logic [CLEAN_STATE_WIDTH-1:0] CLEAN_RUN    = 2'd1;
   localparam logic [CLEAN_STATE_WIDTH-1:0] CLEAN_FINISH = 2'd2;

   localparam int MODE_WIDTH = 3;
   localparam logic [MODE_WIDTH-1:0] STAND_MODE  = 3'd0;
   localparam logic [MODE_WIDTH-1:0] LOW_MODE    = 3'd1;
   localparam logic [MODE_WIDTH-1:0] HIGH_MODE   = 3'd2;
   localparam logic [MODE_WIDTH-1:0] STORM_MODE  = 3'd3;
   localparam logic [MODE_WIDTH-1:0] CLEAN_MODE  = 3'd4;

endpackage

// File: rtl/second_tick_gen.sv
// Free-running CLK_FREQ prescaler with synchronous clear and enable; emits a one-cycle
// tick on the last count of each second.
module second_tick_gen #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int CNT_WIDTH = 27
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(CLK_FREQ - 1);

   logic [CNT_WIDTH-1:0] cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CNT_WIDTH'(1);
      end
   end

   // clear dominates so a cancelled second never produces a stray tick
   assign tick = en & ~clr & (cnt == LAST);

endmodule

// File: rtl/clean_mode_timer.sv
// Self-clean countdown started by a rising edge of clean_mode_toggle; abort cancels it,
// completion raises one-cycle clean_finish / reminder_clear pulses.
module clean_mode_timer
   import clean_mode_timer_pkg::*;
#(
   parameter int CLK_FREQ      = DEF_CLK_FREQ,
   parameter int CLEAN_SECONDS = DEF_CLEAN_SECONDS,
   parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       clean_mode_toggle,
   input  logic       abort,
   output logic       clean_active,
   output logic [7:0] remaining_seconds,
   output logic       clean_finish,
   output logic       reminder_clear
);

   logic [CLEAN_STATE_WIDTH-1:0] state;
   logic [CLEAN_STATE_WIDTH-1:0] state_nxt;
   logic [7:0]                   rem;
   logic [7:0]                   rem_nxt;
   logic                         toggle_d;
   logic                         start;
   logic                         tick;
   logic                         presc_clr;

   // toggle_d follows the input in every state, so edges seen outside IDLE are consumed
   assign start     = clean_mode_toggle & ~toggle_d;
   assign presc_clr = (state != CLEAN_RUN) | abort;

   second_tick_gen #(
      .CLK_FREQ  (CLK_FREQ),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_tick (
      .clk  (clk),
      .rstn (rstn),
      .clr  (presc_clr),
      .en   (state == CLEAN_RUN),
      .tick (tick)
   );

   always_comb begin
      state_nxt = state;
      rem_nxt   = rem;
      case (state)
         CLEAN_IDLE: begin
            rem_nxt = '0;
            if (start && !abort) begin
               state_nxt = CLEAN_RUN;
               rem_nxt   = 8'(CLEAN_SECONDS);
            end
         end
         CLEAN_RUN: begin
            if (abort) begin
               state_nxt = CLEAN_IDLE;
               rem_nxt   = '0;
            end else if (tick && rem != 8'd0) begin
               rem_nxt = rem - 8'd1;
               if (rem == 8'd1) begin
                  state_nxt = CLEAN_FINISH;
               end
            end
         end
         CLEAN_FINISH: begin
            state_nxt = CLEAN_IDLE;
            rem_nxt   = '0;
         end
         default: begin
            state_nxt = CLEAN_IDLE;
            rem_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= CLEAN_IDLE;
         rem      <= '0;
         toggle_d <= 1'b0;
      end else begin
         state    <= state_nxt;
         rem      <= rem_nxt;
         toggle_d <= clean_mode_toggle;
      end
   end

   assign clean_active      = (state == CLEAN_RUN);
   assign clean_finish      = (state == CLEAN_FINISH);
   assign reminder_clear    = (state == CLEAN_FINISH);
   assign remaining_seconds = rem;

endmodule

// File: tb/tb_clean_mode_timer.sv
// Scoreboard bench for clean_mode_timer with CLK_FREQ=10, CLEAN_SECONDS=3.
module tb_clean_mode_timer;

   logic       clk = 1'b0;
   logic       rstn;
   logic       clean_mode_toggle;
   logic       abort;
   logic       clean_active;
   logic [7:0] remaining_seconds;
   logic       clean_finish;
   logic       reminder_clear;

   always #5 clk = ~clk;

   clean_mode_timer #(
      .CLK_FREQ      (10),
      .CLEAN_SECONDS (3),
      .CNT_WIDTH     (4)
   ) dut (
      .clk               (clk),
      .rstn              (rstn),
      .clean_mode_toggle (clean_mode_toggle),
      .abort             (abort),
      .clean_active      (clean_active),
      .remaining_seconds (remaining_seconds),
      .clean_finish      (clean_finish),
      .reminder_clear    (reminder_clear)
   );

   typedef struct {
      int         cyc;
      logic       act;
      logic [7:0] rem;
      logic       fin;
      string      nm;
   } exp_t;

   exp_t exp_q[$];
   int   fin_q[$];
   exp_t e;
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   done    = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic void expect_s(input int c, input logic a, input int r,
                                    input logic f, input string nm);
      exp_t x;
      x.cyc = c; x.act = a; x.rem = 8'(r); x.fin = f; x.nm = nm;
      exp_q.push_back(x);
   endfunction

   // Monitor: all comparisons happen here on the falling edge.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         n_tests++; n_fail++;
         $display("FAIL %s: sample for cycle %0d was skipped (now %0d)", e.nm, e.cyc, cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         e = exp_q.pop_front();
         n_tests++;
         if (clean_active !== e.act || remaining_seconds !== e.rem ||
             clean_finish !== e.fin || reminder_clear !== e.fin) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got act=%0b rem=%0d fin=%0b clr=%0b, want act=%0b rem=%0d fin=%0b clr=%0b",
                     e.nm, cyc, clean_active, remaining_seconds, clean_finish, reminder_clear,
                     e.act, e.rem, e.fin, e.fin);
         end
      end
      while (fin_q.size() > 0 && fin_q[0] < cyc) begin
         n_tests++; n_fail++;
         $display("FAIL missing_finish: pulse expected at cycle %0d did not occur", fin_q.pop_front());
      end
      if (clean_finish || reminder_clear) begin
         n_tests++;
         if (fin_q.size() == 0 || fin_q[0] != cyc) begin
            n_fail++;
            $display("FAIL unexpected_finish: fin=%0b clr=%0b at cycle %0d, no pulse expected",
                     clean_finish, reminder_clear, cyc);
         end else begin
            void'(fin_q.pop_front());
            if (clean_finish !== 1'b1 || reminder_clear !== 1'b1 || clean_active !== 1'b0) begin
               n_fail++;
               $display("FAIL finish_pulse cyc=%0d: fin=%0b clr=%0b act=%0b, want 1 1 0",
                        cyc, clean_finish, reminder_clear, clean_active);
            end
         end
      end
      if (done || cyc > 3000) begin
         if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL timeout: stimulus not complete at cycle %0d, want done", cyc);
         end
         n_tests++;
         if (exp_q.size() != 0 || fin_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d samples and %0d pulses unchecked, want 0 and 0",
                     exp_q.size(), fin_q.size());
         end
         $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
         $finish;
      end
   end

   initial begin
      int n;
      rstn = 1'b0; clean_mode_toggle = 1'b0; abort = 1'b0;

      // Reset, then release with toggle low
      expect_s(2, 0, 0, 0, "reset");
      step(3);
      rstn = 1'b1;
      expect_s(cyc + 2, 0, 0, 0, "post_reset");
      step(4);

      // Nominal run
      n = cyc;
      expect_s(n + 1,  1, 3, 0, "nom_start");
      expect_s(n + 10, 1, 3, 0, "nom_hold3");
      expect_s(n + 11, 1, 2, 0, "nom_rem2");
      expect_s(n + 21, 1, 1, 0, "nom_rem1");
      expect_s(n + 30, 1, 1, 0, "nom_last");
      expect_s(n + 31, 0, 0, 1, "nom_finish");
      expect_s(n + 32, 0, 0, 0, "nom_idle");
      fin_q.push_back(n + 31);
      clean_mode_toggle = 1'b1; step(1); clean_mode_toggle = 1'b0;
      step(34);

      // Abort while remaining=2
      n = cyc;
      expect_s(n + 1,  1, 3, 0, "abt_start");
      expect_s(n + 12, 1, 2, 0, "abt_rem2");
      expect_s(n + 13, 0, 0, 0, "abt_cancel");
      expect_s(n + 14, 0, 0, 0, "abt_stay");
      expect_s(n + 35, 0, 0, 0, "abt_noresume");
      clean_mode_toggle = 1'b1; step(1); clean_mode_toggle = 1'b0;
      step(11);
      abort = 1'b1; step(1); abort = 1'b0;
      step(27);

      // Toggle held high for 50 cycles
      n = cyc;
      expect_s(n + 1,  1, 3, 0, "held_start");
      expect_s(n + 31, 0, 0, 1, "held_finish");
      expect_s(n + 40, 0, 0, 0, "held_norestart");
      expect_s(n + 51, 0, 0, 0, "held_released");
      fin_q.push_back(n + 31);
      clean_mode_toggle = 1'b1; step(50); clean_mode_toggle = 1'b0;
      step(5);

      // Extra edges during RUN and FINISH, abort during FINISH
      n = cyc;
      expect_s(n + 1,  1, 3, 0, "re_start");
      expect_s(n + 6,  1, 3, 0, "re_ignored1");
      expect_s(n + 11, 1, 2, 0, "re_rem2");
      expect_s(n + 16, 1, 2, 0, "re_ignored2");
      expect_s(n + 21, 1, 1, 0, "re_rem1");
      expect_s(n + 31, 0, 0, 1, "re_finish");
      expect_s(n + 32, 0, 0, 0, "re_fin_edge_ign");
      expect_s(n + 34, 0, 0, 0, "re_idle");
      fin_q.push_back(n + 31);
      clean_mode_toggle = 1'b1; step(1); clean_mode_toggle = 1'b0;
      step(4);
      clean_mode_toggle = 1'b1; step(1); clean_mode_toggle = 1'b0;
      step(9);
      clean_mode_toggle = 1'b1; step(1); clean_mode_toggle = 1'b0;
      step(15);
      clean_mode_toggle = 1'b1; abort = 1'b1; step(1); abort = 1'b0;
      step(3);
      clean_mode_toggle = 1'b0;
      step(5);

      // Start edge coinciding with abort in IDLE
      n = cyc;
      expect_s(n + 1, 0, 0, 0, "coll_idle");
      expect_s(n + 3, 0, 0, 0, "coll_stay");
      clean_mode_toggle = 1'b1; abort = 1'b1; step(1);
      clean_mode_toggle = 1'b0; abort = 1'b0;
      step(5);

      // Reset mid-run
      n = cyc;
      expect_s(n + 1,  1, 3, 0, "rst_start");
      expect_s(n + 11, 1, 2, 0, "rst_rem2");
      expect_s(n + 12, 0, 0, 0, "rst_async");
      expect_s(n + 20, 0, 0, 0, "rst_noresume");
      expect_s(n + 45, 0, 0, 0, "rst_nofinish");
      clean_mode_toggle = 1'b1; step(1); clean_mode_toggle = 1'b0;
      step(11);
      rstn = 1'b0;
      step(2);
      rstn = 1'b1;
      step(35);

      done = 1'b1;
   end

endmodule
